// File: rtl/qarma_tweak_schedule.sv
// Iterative QARMAv2-128 round-tweak generator: streams phi^r(T) forward for encryption,
// or winds up to phi^(ROUNDS-1)(T) and streams back with phi^-1 for decryption.
module qarma_tweak_schedule #(
  parameter int ROUNDS = 13,
  parameter int CW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_tweak,
  input  logic          in_dec,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_tweak,
  output logic [CW-1:0] out_round,
  output logic          out_last,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // While out_valid=1 and out_ready=0 every out_* signal holds its value.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WIND = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_R = CW'(ROUNDS - 1);

  localparam int PHI [32] = '{1, 10, 14, 22, 18, 25, 29, 21, 0, 8, 12, 4, 19, 27, 31, 23,
                              17, 26, 30, 6, 2, 9, 13, 5, 16, 24, 28, 20, 3, 11, 15, 7};
  localparam int IPHI [32] = '{8, 0, 20, 28, 11, 23, 19, 31, 9, 21, 1, 29, 10, 22, 2, 30,
                               24, 16, 4, 12, 27, 7, 3, 15, 25, 5, 17, 13, 26, 6, 18, 14};

  // Output cell i takes input cell tab[i]; cell i occupies bits [127-4i -: 4].
  function automatic logic [127:0] permute(input logic [127:0] t, input logic inv);
    logic [127:0] p;
    int src;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      src = inv ? IPHI[i] : PHI[i];
      p[127-4*i -: 4] = t[127-4*src -: 4];
    end
    return p;
  endfunction

  state_t        state;
  logic [127:0]  tw;
  logic [CW-1:0] cnt;
  logic          dir;
  logic [127:0]  tw_fwd;
  logic [127:0]  tw_bwd;

  assign tw_fwd    = permute(tw, 1'b0);
  assign tw_bwd    = permute(tw, 1'b1);
  assign out_tweak = tw;
  assign out_round = cnt;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tw        <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            tw       <= in_tweak;
            cnt      <= '0;
            dir      <= in_dec;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            out_last <= 1'b0;
            if (in_dec) begin
              state <= S_WIND;
            end else begin
              state     <= S_EMIT;
              out_valid <= 1'b1;
            end
          end
        end
        S_WIND: begin
          // The step that reaches phi^(ROUNDS-1) also opens the output stream.
          tw  <= tw_fwd;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_R - 1'b1) begin
            state     <= S_EMIT;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else if (dir) begin
              tw       <= tw_bwd;
              cnt      <= cnt - 1'b1;
              out_last <= (cnt == CW'(1));
            end else begin
              tw       <= tw_fwd;
              cnt      <= cnt + 1'b1;
              out_last <= (cnt == LAST_R - 1'b1);
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qarma_tweak_schedule.sv
// Scoreboard bench for qarma_tweak_schedule: a cell-array model of phi builds each job's
// round tweak list, the expected beats are queued, and a monitor pops them on every accept.
module tb_qarma_tweak_schedule;

  localparam int ROUNDS = 13;
  localparam int CW     = 5;

  localparam int PHI_TB [32] = '{1, 10, 14, 22, 18, 25, 29, 21, 0, 8, 12, 4, 19, 27, 31, 23,
                                 17, 26, 30, 6, 2, 9, 13, 5, 16, 24, 28, 20, 3, 11, 15, 7};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_tweak = '0;
  logic          in_dec = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  out_tweak;
  logic [CW-1:0] out_round;
  logic          out_last;
  logic          busy;
  logic [1:0]    dbg_state;

  qarma_tweak_schedule #(.ROUNDS(ROUNDS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_tweak(in_tweak), .in_dec(in_dec), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_tweak(out_tweak), .out_round(out_round),
    .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [133:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference phi: split into 32 nibble cells, gather through the table, repack.
  function automatic logic [127:0] phi_m(input logic [127:0] t);
    logic [3:0]   c [32];
    logic [127:0] r;
    for (int i = 0; i < 32; i++) c[i] = t[127-4*i -: 4];
    r = '0;
    for (int i = 0; i < 32; i++) r[127-4*i -: 4] = c[PHI_TB[i]];
    return r;
  endfunction

  task automatic push_job(input logic [127:0] t, input logic dec);
    logic [127:0] seq [ROUNDS];
    logic [133:0] e;
    seq[0] = t;
    for (int r = 1; r < ROUNDS; r++) seq[r] = phi_m(seq[r-1]);
    for (int k = 0; k < ROUNDS; k++) begin
      int r;
      r = dec ? (ROUNDS - 1 - k) : k;
      e = {(k == ROUNDS - 1), CW'(r), seq[r]};
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  logic          held = 1'b0;
  logic [127:0]  held_tw;
  logic [CW-1:0] held_r;

  task automatic monitor_loop();
    logic [133:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", out_valid, 1);
          check("stall_tweak", out_tweak, held_tw);
          check("stall_round", out_round, held_r);
        end
        if (out_valid) check("in_ready_while_emit", in_ready, 0);
        if (out_valid && out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: round %0d tweak %h", out_round, out_tweak);
          end else begin
            e = exp_q.pop_front();
            check("beat_tweak", out_tweak, e[127:0]);
            check("beat_round", out_round, e[132:128]);
            check("beat_last", out_last, e[133]);
          end
        end else if (out_valid) begin
          held    = 1'b1;
          held_tw = out_tweak;
          held_r  = out_round;
        end else begin
          held = 1'b0;
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Returns at accept edge + #1 with the job's beats queued.
  task automatic start_job(input logic [127:0] t, input logic dec);
    int n;
    in_tweak = t;
    in_dec   = dec;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready && !flush) break;
      n++;
      if (n > 300) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (n > 300) fail("accept_timeout");
    else push_job(t, dec);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) break;
      n++;
      if (n > limit) begin
        fail("wait_idle");
        break;
      end
    end
  endtask

  task automatic wait_round(input int r);
    int n;
    n = 0;
    while (!(out_valid && out_round == CW'(r)) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail("wait_round");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_tweak"}, out_tweak, 0);
    check({tag, "_out_round"}, out_round, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic check_after_flush(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt"}, out_round, 0);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] T1  = 128'h00000000_F0000000_00000000_00000000;
  localparam logic [127:0] T1R1 = 128'h00000000_0F000000_00000000_00000000;
  localparam logic [127:0] T1R2 = 128'h00000000_00000000_00000F00_00000000;

  initial begin
    int lat;
    int last_cyc;
    int acc_cyc;
    int n;
    logic [127:0] t;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    fork
      monitor_loop();
    join_none

    // Test 1: encryption of the single-cell tweak, continuous ready.
    out_ready = 1'b1;
    start_job(T1, 1'b0);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("enc_latency", lat, 1);
    check("enc_r0", out_tweak, T1);
    @(posedge clk); #1;
    check("enc_r1", out_tweak, T1R1);
    @(posedge clk); #1;
    check("enc_r2", out_tweak, T1R2);
    wait_idle(100);

    // Test 2: decryption of the same tweak.
    start_job(T1, 1'b1);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("dec_latency", lat, ROUNDS);
    check("dec_first_round", out_round, ROUNDS - 1);
    wait_idle(100);

    // Test 3: random stalls on both directions.
    for (int j = 0; j < 4; j++) begin
      out_ready = 1'($urandom_range(0, 1));
      start_job(rand128(), 1'(j % 2));
      n = 0;
      while (busy && n < 500) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      out_ready = 1'b1;
      wait_idle(100);
    end

    // Test 4a: flush during WIND.
    start_job(rand128(), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("wind_busy", busy, 1);
    check("wind_no_valid", out_valid, 0);
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    check_after_flush("flush_wind");
    t = rand128();
    start_job(t, 1'b0);
    check("post_flush_r0", out_tweak, t);
    wait_idle(100);

    // Test 4b: flush during EMIT at r=4.
    start_job(rand128(), 1'b0);
    wait_round(4);
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    check_after_flush("flush_emit");
    t = rand128();
    start_job(t, 1'b0);
    check("post_flush2_r0", out_tweak, t);
    wait_idle(100);

    // Flush together with in_valid in IDLE: no capture.
    in_valid = 1'b1;
    in_tweak = rand128();
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_beats_capture", busy, 0);

    // Test 5: asynchronous reset during EMIT at r=7.
    start_job(rand128(), 1'b0);
    wait_round(7);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_vals("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_job(rand128(), 1'b1);
    wait_idle(100);

    // Test 6: back-to-back enc then dec with in_valid held high.
    t = rand128();
    in_tweak = t;
    in_dec = 1'b0;
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    @(posedge clk); #1;
    push_job(t, 1'b0);
    t = rand128();
    in_tweak = t;
    in_dec = 1'b1;
    last_cyc = -100;
    acc_cyc = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) last_cyc = cyc;
      if (in_ready) begin acc_cyc = cyc; break; end
      n++;
      if (n > 100) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (n > 100) fail("b2b_accept");
    else push_job(t, 1'b1);
    check("b2b_gap", acc_cyc - last_cyc, 1);
    wait_idle(100);

    // 1000 random tweaks, each encrypted then decrypted.
    for (int j = 0; j < 1000; j++) begin
      t = rand128();
      start_job(t, 1'b0);
      start_job(t, 1'b1);
    end
    wait_idle(200);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
